posu_ctl: RTL and testbench



---
 rtl/posu_ctl_pkg.sv | 34 +++
 rtl/posu_ctl_if.sv | 44 ++++
 rtl/posu_wb_sched.sv | 50 +++++
 rtl/posu_ctl.sv | 81 ++++++++
 tb/tb_posu_ctl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/posu_ctl_pkg.sv
// Shared types for the POSU issue/writeback scheduler: request packet, op encoding,
// and request decode helpers.
package posu_ctl_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } posu_op_t;

  typedef struct packed {
    logic valid;
    logic add;
    logic sub;
    logic mul;
    logic div;
  } posu_pkt_t;

  localparam int RSV_W = 32;

  // A valid packet with no op bit set carries no work and is silently dropped.
  function automatic logic posu_has_op(input posu_pkt_t p);
    return p.valid & (p.add | p.sub | p.mul | p.div);
  endfunction

  function automatic posu_op_t posu_decode(input posu_pkt_t p);
    if (p.div)      return DIV;
    else if (p.mul) return MUL;
    else if (p.sub) return SUB;
    else            return ADD;
  endfunction

endpackage

// File: rtl/posu_ctl_if.sv
// Decode <-> POSU scheduler bus. Optional PMU pulses exist only with RV_POSU_PMU_EN.
interface posu_ctl_if;
  import posu_ctl_pkg::*;

  posu_pkt_t  i0_ap;
  logic [4:0] i0_rd;
  posu_pkt_t  i1_ap;
  logic [4:0] i1_rd;
  logic       flush;

  logic       posu_i0_stall;
  logic       posu_i1_stall;
  logic       posu_issue_valid;
  logic       posu_issue_sel;
  posu_op_t   posu_issue_op;
  logic       posu_wb_valid;
  logic [4:0] posu_wb_rd;
  logic       posu_wb_pipe;
  logic       posu_div_busy;
`ifdef RV_POSU_PMU_EN
  logic       posu_pmu_issue;
  logic       posu_pmu_wb_stall;
  logic       posu_pmu_div_stall;
`endif

  modport master (
    output i0_ap, i0_rd, i1_ap, i1_rd, flush,
    input  posu_i0_stall, posu_i1_stall, posu_issue_valid, posu_issue_sel,
           posu_issue_op, posu_wb_valid, posu_wb_rd, posu_wb_pipe, posu_div_busy
`ifdef RV_POSU_PMU_EN
  , input  posu_pmu_issue, posu_pmu_wb_stall, posu_pmu_div_stall
`endif
  );

  modport slave (
    input  i0_ap, i0_rd, i1_ap, i1_rd, flush,
    output posu_i0_stall, posu_i1_stall, posu_issue_valid, posu_issue_sel,
           posu_issue_op, posu_wb_valid, posu_wb_rd, posu_wb_pipe, posu_div_busy
`ifdef RV_POSU_PMU_EN
  , output posu_pmu_issue, posu_pmu_wb_stall, posu_pmu_div_stall
`endif
  );

endinterface

// File: rtl/posu_wb_sched.sv
// Writeback slot reservation: rsv[k] marks a result due k cycles from now, with the
// matching destination register and pipe carried alongside in shift registers.
module posu_wb_sched
  import posu_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       set,
  input  logic [4:0] set_lat,
  input  logic [4:0] rd,
  input  logic       pipe,
  input  logic       flush,
  input  logic [4:0] chk_lat,
  output logic       slot_free,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_pipe
);

  logic [RSV_W-1:0]        rsv, rsv_nxt;
  logic [RSV_W-1:0][4:0]   rd_q, rd_nxt;
  logic [RSV_W-1:0]        pipe_q, pipe_nxt;

  // The new entry lands at L-1 because the whole vector shifts down this same edge.
  always_comb begin
    rsv_nxt  = {1'b0, rsv[RSV_W-1:1]};
    rd_nxt   = {5'd0, rd_q[RSV_W-1:1]};
    pipe_nxt = {1'b0, pipe_q[RSV_W-1:1]};
    if (set) begin
      rsv_nxt[set_lat - 5'd1]  = 1'b1;
      rd_nxt[set_lat - 5'd1]   = rd;
      pipe_nxt[set_lat - 5'd1] = pipe;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) rsv <= '0;
    else       rsv <= rsv_nxt;
  end

  always_ff @(posedge clk) begin
    rd_q   <= rd_nxt;
    pipe_q <= pipe_nxt;
  end

  assign slot_free = ~rsv[chk_lat];
  assign wb_valid  = rsv[0] & ~flush;
  assign wb_rd     = wb_valid ? rd_q[0] : 5'd0;
  assign wb_pipe   = wb_valid & pipe_q[0];

endmodule

// File: rtl/posu_ctl.sv
// POSU issue arbiter, divider tracker and writeback scheduler front end.
// Optional PMU event outputs are built when RV_POSU_PMU_EN is defined.
module posu_ctl
  import posu_ctl_pkg::*;
#(
  parameter int ADD_LAT    = 2,
  parameter int MUL_LAT    = 3,
  parameter int DIV_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  posu_ctl_if.slave   bus
);

  logic       kill;
  logic       act0, act1;
  logic       cand_act, cand_sel, cand_div;
  posu_op_t   cand_op;
  logic [4:0] cand_rd, cand_lat;
  logic       slot_free, div_free, issue;
  logic [4:0] div_cnt;

  function automatic logic [4:0] op_lat(input posu_op_t op);
    case (op)
      ADD, SUB: return 5'(ADD_LAT);
      MUL:      return 5'(MUL_LAT);
      default:  return 5'(DIV_CYCLES);
    endcase
  endfunction

  // Reset behaves exactly like a flush for all in-flight work.
  assign kill = bus.flush | rst;

  assign act0 = posu_has_op(bus.i0_ap);
  assign act1 = posu_has_op(bus.i1_ap);

  // i0 is older: when it holds work, i1 is not even considered.
  assign cand_act = act0 | act1;
  assign cand_sel = ~act0;
  assign cand_op  = act0 ? posu_decode(bus.i0_ap) : posu_decode(bus.i1_ap);
  assign cand_rd  = act0 ? bus.i0_rd : bus.i1_rd;
  assign cand_lat = op_lat(cand_op);
  assign cand_div = (cand_op == DIV);

  assign div_free = (div_cnt == 5'd0);
  assign issue    = cand_act & slot_free & (~cand_div | div_free) & ~kill;

  posu_wb_sched u_wb_sched (
    .clk       (clk),
    .set       (issue),
    .set_lat   (cand_lat),
    .rd        (cand_rd),
    .pipe      (cand_sel),
    .flush     (kill),
    .chk_lat   (cand_lat),
    .slot_free (slot_free),
    .wb_valid  (bus.posu_wb_valid),
    .wb_rd     (bus.posu_wb_rd),
    .wb_pipe   (bus.posu_wb_pipe)
  );

  always_ff @(posedge clk) begin
    if (kill)                   div_cnt <= 5'd0;
    else if (issue && cand_div) div_cnt <= 5'(DIV_CYCLES - 1);
    else if (!div_free)         div_cnt <= div_cnt - 5'd1;
  end

  assign bus.posu_issue_valid = issue;
  assign bus.posu_issue_sel   = issue & cand_sel;
  assign bus.posu_issue_op    = issue ? cand_op : ADD;
  assign bus.posu_i0_stall    = act0 & ~issue & ~kill;
  assign bus.posu_i1_stall    = act1 & ~(issue & cand_sel) & ~kill;
  assign bus.posu_div_busy    = ~div_free;

`ifdef RV_POSU_PMU_EN
  assign bus.posu_pmu_issue     = issue;
  assign bus.posu_pmu_wb_stall  = cand_act & ~slot_free & ~(cand_div & ~div_free) & ~kill;
  assign bus.posu_pmu_div_stall = cand_act & cand_div & ~div_free & ~kill;
`endif

endmodule

// File: tb/tb_posu_ctl.sv
// Bench for posu_ctl: directed scenarios then random traffic, checked against a
// cycle-indexed writeback calendar model. PMU checks compile in with RV_POSU_PMU_EN.
module tb_posu_ctl;
  import posu_ctl_pkg::*;

  localparam int ADD_LAT    = 2;
  localparam int MUL_LAT    = 3;
  localparam int DIV_CYCLES = 16;

  localparam logic [3:0] O_NONE = 4'b0000;
  localparam logic [3:0] O_ADD  = 4'b0001;
  localparam logic [3:0] O_SUB  = 4'b0010;
  localparam logic [3:0] O_MUL  = 4'b0100;
  localparam logic [3:0] O_DIV  = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posu_ctl_if bus ();

  posu_ctl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int now        = 0;

  // Model: calendar of future writebacks keyed by absolute cycle, plus the first
  // cycle at which the divider is free again.
  bit wb_v    [int];
  int wb_rd   [int];
  int wb_pipe [int];
  int div_end = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, now, obs, exp);
    end
  endtask

  function automatic posu_pkt_t pk(input bit v, input logic [3:0] o);
    posu_pkt_t p;
    p.valid = v;
    p.add   = o[0];
    p.sub   = o[1];
    p.mul   = o[2];
    p.div   = o[3];
    return p;
  endfunction

  function automatic int dec(input logic [3:0] o);
    return o[3] ? 3 : o[2] ? 2 : o[1] ? 1 : 0;
  endfunction

  function automatic int lat_of(input int op);
    return (op < 2) ? ADD_LAT : (op == 2) ? MUL_LAT : DIV_CYCLES;
  endfunction

  task automatic step(input bit v0, input logic [3:0] o0, input int rd0,
                      input bit v1, input logic [3:0] o1, input int rd1,
                      input bit fl, input bit r);
    bit kill, a0, a1, iss, blk_rsv, blk_div;
    int sel, op, lat, rdc, e_wbv, e_rd, e_pipe, e_busy;
    @(negedge clk);
    rst       = r;
    bus.flush = fl;
    bus.i0_ap = pk(v0, o0);
    bus.i0_rd = 5'(rd0);
    bus.i1_ap = pk(v1, o1);
    bus.i1_rd = 5'(rd1);
    #1;
    kill = fl | r;
    a0 = v0 && (o0 != 4'b0);
    a1 = v1 && (o1 != 4'b0);
    iss = 0; blk_rsv = 0; blk_div = 0;
    sel = 0; op = 0; lat = 0; rdc = 0;
    e_wbv  = (!kill && wb_v.exists(now)) ? 1 : 0;
    e_rd   = e_wbv ? wb_rd[now] : 0;
    e_pipe = e_wbv ? wb_pipe[now] : 0;
    e_busy = (now < div_end) ? 1 : 0;
    if (!kill && (a0 || a1)) begin
      sel     = a0 ? 0 : 1;
      op      = dec(a0 ? o0 : o1);
      lat     = lat_of(op);
      rdc     = a0 ? rd0 : rd1;
      blk_rsv = wb_v.exists(now + lat);
      blk_div = (op == 3) && (now < div_end);
      iss     = !blk_rsv && !blk_div;
    end
    chk("issue_valid", 32'(bus.posu_issue_valid), 32'(iss));
    chk("issue_sel",   32'(bus.posu_issue_sel),   iss ? sel : 0);
    chk("issue_op",    32'(bus.posu_issue_op),    iss ? op : 0);
    chk("i0_stall",    32'(bus.posu_i0_stall),    32'(a0 && !kill && !(iss && sel == 0)));
    chk("i1_stall",    32'(bus.posu_i1_stall),    32'(a1 && !kill && !(iss && sel == 1)));
    chk("wb_valid",    32'(bus.posu_wb_valid),    e_wbv);
    chk("wb_rd",       32'(bus.posu_wb_rd),       e_rd);
    chk("wb_pipe",     32'(bus.posu_wb_pipe),     e_pipe);
    chk("div_busy",    32'(bus.posu_div_busy),    e_busy);
`ifdef RV_POSU_PMU_EN
    chk("pmu_issue",     32'(bus.posu_pmu_issue),     32'(iss));
    chk("pmu_wb_stall",  32'(bus.posu_pmu_wb_stall),  32'(blk_rsv && !blk_div));
    chk("pmu_div_stall", 32'(bus.posu_pmu_div_stall), 32'(blk_div));
`endif
    if (wb_v.exists(now)) begin
      wb_v.delete(now); wb_rd.delete(now); wb_pipe.delete(now);
    end
    if (kill) begin
      wb_v.delete(); wb_rd.delete(); wb_pipe.delete();
      div_end = now;
    end else if (iss) begin
      wb_v[now + lat]    = 1'b1;
      wb_rd[now + lat]   = rdc;
      wb_pipe[now + lat] = sel;
      if (op == 3) div_end = now + DIV_CYCLES;
    end
    now++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, O_NONE, 0, 0, O_NONE, 0, 0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.i0_ap = '0;
    bus.i0_rd = '0;
    bus.i1_ap = '0;
    bus.i1_rd = '0;
    repeat (3) @(posedge clk);

    // reset state
    step(0, O_NONE, 0, 0, O_NONE, 0, 0, 1);
    idle(2);

    // single add, writeback two cycles later
    step(1, O_ADD, 5, 0, O_NONE, 0, 0, 0);
    idle(4);

    // i0 mul beats i1 add; the add collides once more then issues
    step(1, O_MUL, 3, 1, O_ADD, 4, 0, 0);
    step(0, O_NONE, 0, 1, O_ADD, 4, 0, 0);
    step(0, O_NONE, 0, 1, O_ADD, 4, 0, 0);
    idle(5);

    // back-to-back divs: second waits for the divider
    step(1, O_DIV, 7, 0, O_NONE, 0, 0, 0);
    for (int i = 0; i < DIV_CYCLES; i++) step(1, O_DIV, 8, 0, O_NONE, 0, 0, 0);
    idle(DIV_CYCLES + 2);

    // add then mul: no collision; mul then add: add stalls one cycle
    step(1, O_ADD, 1, 0, O_NONE, 0, 0, 0);
    step(1, O_MUL, 2, 0, O_NONE, 0, 0, 0);
    idle(4);
    step(1, O_MUL, 9, 0, O_NONE, 0, 0, 0);
    step(1, O_ADD, 10, 0, O_NONE, 0, 0, 0);
    step(1, O_ADD, 10, 0, O_NONE, 0, 0, 0);
    idle(4);

    // back-to-back subs from i1 every cycle
    for (int i = 0; i < 4; i++) step(0, O_NONE, 0, 1, O_SUB, 20 + i, 0, 0);
    idle(4);

    // flush mid-div cancels the writeback and frees the divider
    step(1, O_DIV, 11, 0, O_NONE, 0, 0, 0);
    idle(4);
    step(1, O_ADD, 12, 0, O_NONE, 0, 1, 0);
    step(0, O_NONE, 0, 1, O_DIV, 13, 0, 0);
    idle(DIV_CYCLES + 2);

    // flush on a writeback cycle suppresses it
    step(1, O_ADD, 14, 0, O_NONE, 0, 0, 0);
    idle(1);
    step(0, O_NONE, 0, 0, O_NONE, 0, 1, 0);
    idle(3);

    // reset mid-div behaves like flush
    step(1, O_DIV, 15, 0, O_NONE, 0, 0, 0);
    idle(3);
    step(0, O_NONE, 0, 0, O_NONE, 0, 0, 1);
    idle(DIV_CYCLES + 2);

    // dropped valid-without-op, multi-hot priority
    step(1, O_NONE, 16, 1, O_ADD, 17, 0, 0);
    step(1, 4'b1111, 18, 1, 4'b0110, 19, 0, 0);
    step(0, O_NONE, 0, 1, 4'b0110, 19, 0, 0);
    idle(DIV_CYCLES + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom), int'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 7, 4'($urandom), int'($urandom_range(0, 31)),
           $urandom_range(0, 59) == 0, $urandom_range(0, 249) == 0);
    end
    idle(DIV_CYCLES + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
